status_reporter: RTL and testbench
==================================

# status_reporter

Host-bound telemetry framer for the FT245 transmit simple interface (`tx_data_si`/`tx_valid_si`/`tx_ready_si`), which the receive-to-modulator datapath currently leaves unused. The block counts RX-path and modulator-side FIFO events. Once per report period it snapshots those counts and streams a fixed-format status frame to the host through the FT245 wrapper. It sits beside `data_fifo` in the top level and only observes the FIFO strobes; it never drives them.

## Interface
- `PERIOD_CLKS`, 1280000: report period in `clk` cycles (10 ms at 128 MHz); legal range ≥ 16.
- `clk`  in  1  system clock (128 MHz PLL output).
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  report timer run enable.
- `rx_valid_si`  in  1  FT245 RX byte-valid strobe.
- `fifo_full`  in  1  data FIFO full flag.
- `fifo_empty`  in  1  data FIFO empty flag.
- `read_sample`  in  1  modulator FIFO read strobe.
- `tx_data_si`  out  8  frame byte to FT245 wrapper.
- `tx_valid_si`  out  1  `tx_data_si` valid.
- `tx_ready_si`  in  1  wrapper accepts byte.

## Operation
- Live counters, evaluated every cycle:
  - `rx_cnt` (16 b): increments on `rx_valid_si & !fifo_full`.
  - `rd_cnt` (16 b): increments on `read_sample & !fifo_empty`.
  - `ovf_cnt` (8 b): increments on `rx_valid_si & fifo_full`.
  - `udf_cnt` (8 b): increments on `read_sample & fifo_empty`.
  - All four saturate at all-ones; no wrap.
- Timer:
  - Counts 0..`PERIOD_CLKS`-1 while `enable`=1; tick on terminal count, then wraps to 0.
  - When `enable`=0 the timer holds at 0. A frame in progress still completes.
  - A tick sets `pending`.
- FSM states:
  - IDLE: if `pending`, load the snapshot, clear `pending`, go to SEND. The same edge clears all live counters. An event in that same cycle counts as 1 in the new live window, not in the snapshot.
  - SEND: byte index `idx` advances on each `tx_valid_si & tx_ready_si`. On acceptance of the last byte: `seq` += 1 (8 b, wraps 0xFF→0x00), go to IDLE.
  - A tick during SEND only sets `pending`. Ticks while `pending` is already set are dropped; the counters keep accumulating.
- Frame, MSB first:
  - byte 0: 0xA5 (sync)
  - byte 1: `seq`
  - bytes 2-3: `rx_cnt`
  - bytes 4-5: `rd_cnt`
  - byte 6: `ovf_cnt`
  - byte 7: `udf_cnt`
  - byte 8: checksum (when enabled, see Configuration)
- Handshake:
  - `tx_valid_si` stays high for the whole of SEND.
  - `tx_data_si` is registered, driven from the snapshot by `idx`, and held stable while `tx_valid_si & !tx_ready_si`.
  - No byte is skipped or duplicated.
- Reset values: `tx_valid_si`=0, `tx_data_si`=0x00, `seq`=0, all counters=0, timer=0, `pending`=0, state IDLE.
- Reset mid-frame aborts the frame. No partial resume; the next frame starts at byte 0 with `seq`=0.

## Timing
- Tick at edge E (timer passes terminal count): `pending`=1 after E.
- Snapshot load and IDLE→SEND at E+1; `tx_valid_si`=1 with byte 0 from E+1.
- With `tx_ready_si` held high, one byte transfers per cycle. A 9-byte frame occupies E+1..E+9.
- The last-byte accept edge returns the FSM to IDLE with `tx_valid_si`=0. There is at least one idle cycle between back-to-back frames.
- All outputs are registered. There is no combinational path from `tx_ready_si` to any output.

## Configuration
- `STATUS_CHECKSUM_EN` defined:
  - Frame is 9 bytes.
  - byte 8 = XOR of bytes 1..7, accumulated as bytes are sent or computed at snapshot load; it must equal that XOR either way.
- Not defined:
  - Frame is 8 bytes (bytes 0-7). The last byte is byte 7.
  - No checksum logic is synthesized.

## Test plan
- Checksum build, `PERIOD_CLKS`=100, `tx_ready_si`=1, 5 accepted writes and 3 non-empty reads in the first period -> frame A5 00 00 05 00 03 00 00 06, starting the cycle after the tick, valid contiguous for 9 cycles.
- Same stimulus, `tx_ready_si` toggling 1/0 each cycle -> identical byte sequence; `tx_data_si` stable on every stalled cycle; 9 transfers total.
- `fifo_full`=1 with 3 `rx_valid_si` pulses, plus 300 `read_sample` pulses with `fifo_empty`=1 -> `rx_cnt`=0x0000, byte 6 = 0x03, byte 7 = 0xFF (saturated).
- Event coincident with the snapshot-load edge, `tx_ready_si` held low past the next tick -> event absent from frame `seq`=0 and counted in frame `seq`=1; frame 1 follows after exactly one idle cycle once ready rises; only one extra frame despite multiple ticks.
- `rst` asserted at byte 4 of a frame -> `tx_valid_si`=0 the cycle after the reset edge; next frame is A5 00 with fresh counts.
- Non-checksum build -> 8-byte frame ending at `udf_cnt`; `enable`=0 -> no frames, counters still count, and the next frame after re-enable reports the accumulated totals.

Source files
------------

// File: rtl/status_reporter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : status_reporter                                               |
// | Purpose  : Counts RX/modulator FIFO events and streams a periodic status |
// |            frame to the FT245 transmit interface. Optional checksum byte |
// |            is built when STATUS_CHECKSUM_EN is defined.                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module status_reporter #(
  parameter int unsigned PERIOD_CLKS = 1280000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rx_valid_si,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  input  logic       read_sample,
  output logic [7:0] tx_data_si,
  output logic       tx_valid_si,
  input  logic       tx_ready_si
);

  localparam int unsigned     c_tmr_w    = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(PERIOD_CLKS - 1);
  localparam logic [7:0]      c_sync     = 8'hA5;
`ifdef STATUS_CHECKSUM_EN
  localparam logic [3:0]      c_last_idx = 4'd8;
`else
  localparam logic [3:0]      c_last_idx = 4'd7;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_tmr_w-1:0]   r_timer;
  logic                 r_pending;
  logic [3:0]           r_idx;
  logic [7:0]           r_seq;
  logic [7:0]           r_tx_data;
  logic                 r_tx_valid;

  logic [15:0]          r_rx_cnt;
  logic [15:0]          r_rd_cnt;
  logic [7:0]           r_ovf_cnt;
  logic [7:0]           r_udf_cnt;

  logic [15:0]          r_snap_rx;
  logic [15:0]          r_snap_rd;
  logic [7:0]           r_snap_ovf;
  logic [7:0]           r_snap_udf;
`ifdef STATUS_CHECKSUM_EN
  logic [7:0]           r_snap_csum;
  logic [7:0]           w_csum;
`endif

  logic                 w_rx_acc;
  logic                 w_rd_acc;
  logic                 w_ovf_ev;
  logic                 w_udf_ev;
  logic                 w_tick;
  logic                 w_load;
  logic [3:0]           w_next_idx;
  logic [7:0]           w_next_byte;

  assign w_rx_acc   = rx_valid_si & ~fifo_full;
  assign w_rd_acc   = read_sample & ~fifo_empty;
  assign w_ovf_ev   = rx_valid_si &  fifo_full;
  assign w_udf_ev   = read_sample &  fifo_empty;
  assign w_tick     = enable & (r_timer == c_tmr_last);
  assign w_load     = (r_state == ST_IDLE) & r_pending;
  assign w_next_idx = r_idx + 4'd1;

  assign tx_data_si  = r_tx_data;
  assign tx_valid_si = r_tx_valid;

  // Report period timer; held at zero while disabled.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_timer <= '0;
    end else if (r_timer == c_tmr_last) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + c_tmr_w'(1);
    end
  end

  // A tick arriving while a request is already pending is simply absorbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (w_load) begin
      r_pending <= 1'b0;
    end else if (w_tick) begin
      r_pending <= 1'b1;
    end
  end

  // Live counters restart on the snapshot edge, keeping any coincident event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_ovf_cnt <= '0;
      r_udf_cnt <= '0;
    end else if (w_load) begin
      r_rx_cnt  <= {15'd0, w_rx_acc};
      r_rd_cnt  <= {15'd0, w_rd_acc};
      r_ovf_cnt <= {7'd0, w_ovf_ev};
      r_udf_cnt <= {7'd0, w_udf_ev};
    end else begin
      if (w_rx_acc && (r_rx_cnt != 16'hFFFF)) r_rx_cnt  <= r_rx_cnt + 16'd1;
      if (w_rd_acc && (r_rd_cnt != 16'hFFFF)) r_rd_cnt  <= r_rd_cnt + 16'd1;
      if (w_ovf_ev && (r_ovf_cnt != 8'hFF))   r_ovf_cnt <= r_ovf_cnt + 8'd1;
      if (w_udf_ev && (r_udf_cnt != 8'hFF))   r_udf_cnt <= r_udf_cnt + 8'd1;
    end
  end

`ifdef STATUS_CHECKSUM_EN
  assign w_csum = r_seq ^ r_rx_cnt[15:8] ^ r_rx_cnt[7:0] ^ r_rd_cnt[15:8]
                ^ r_rd_cnt[7:0] ^ r_ovf_cnt ^ r_udf_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_rx   <= '0;
      r_snap_rd   <= '0;
      r_snap_ovf  <= '0;
      r_snap_udf  <= '0;
`ifdef STATUS_CHECKSUM_EN
      r_snap_csum <= '0;
`endif
    end else if (w_load) begin
      r_snap_rx   <= r_rx_cnt;
      r_snap_rd   <= r_rd_cnt;
      r_snap_ovf  <= r_ovf_cnt;
      r_snap_udf  <= r_udf_cnt;
`ifdef STATUS_CHECKSUM_EN
      r_snap_csum <= w_csum;
`endif
    end
  end

  // Byte following the one currently on the bus; byte 0 is loaded directly.
  always_comb begin
    w_next_byte = 8'h00;
    case (w_next_idx)
      4'd1:    w_next_byte = r_seq;
      4'd2:    w_next_byte = r_snap_rx[15:8];
      4'd3:    w_next_byte = r_snap_rx[7:0];
      4'd4:    w_next_byte = r_snap_rd[15:8];
      4'd5:    w_next_byte = r_snap_rd[7:0];
      4'd6:    w_next_byte = r_snap_ovf;
      4'd7:    w_next_byte = r_snap_udf;
`ifdef STATUS_CHECKSUM_EN
      4'd8:    w_next_byte = r_snap_csum;
`endif
      default: w_next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_seq      <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pending) begin
            r_state    <= ST_SEND;
            r_idx      <= '0;
            r_tx_data  <= c_sync;
            r_tx_valid <= 1'b1;
          end
        end
        ST_SEND: begin
          if (tx_ready_si) begin
            if (r_idx == c_last_idx) begin
              r_state    <= ST_IDLE;
              r_idx      <= '0;
              r_seq      <= r_seq + 8'd1;
              r_tx_data  <= 8'h00;
              r_tx_valid <= 1'b0;
            end else begin
              r_idx      <= w_next_idx;
              r_tx_data  <= w_next_byte;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_status_reporter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_status_reporter                                            |
// | Purpose  : Directed plus random stimulus against a frame-queue model.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_status_reporter;

  localparam int P = 100;
`ifdef STATUS_CHECKSUM_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst, enable, rx_valid_si, fifo_full, fifo_empty, read_sample, tx_ready_si;
  logic [7:0] tx_data_si;
  logic       tx_valid_si;

  status_reporter #(.PERIOD_CLKS(P)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .rx_valid_si (rx_valid_si),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .read_sample (read_sample),
    .tx_data_si  (tx_data_si),
    .tx_valid_si (tx_valid_si),
    .tx_ready_si (tx_ready_si)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: live counts as integers, outgoing frame as a byte queue.
  int           m_timer, m_rx, m_rd, m_ovf, m_udf, m_seq;
  bit           m_pending;
  byte unsigned m_q[$];
  byte unsigned cap[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_edge();
    bit acc, ld, tk;
    byte unsigned x;
    if (rst) begin
      m_timer = 0; m_rx = 0; m_rd = 0; m_ovf = 0; m_udf = 0; m_seq = 0;
      m_pending = 0;
      m_q.delete();
      return;
    end
    acc = (m_q.size() != 0) && tx_ready_si;
    ld  = (m_q.size() == 0) && m_pending;
    tk  = enable && (m_timer == P - 1);
    if (ld) begin
      m_q.push_back(8'hA5);
      m_q.push_back(byte'(m_seq));
      m_q.push_back(byte'(m_rx >> 8));
      m_q.push_back(byte'(m_rx & 255));
      m_q.push_back(byte'(m_rd >> 8));
      m_q.push_back(byte'(m_rd & 255));
      m_q.push_back(byte'(m_ovf));
      m_q.push_back(byte'(m_udf));
      if (FL == 9) begin
        x = 0;
        for (int k = 1; k < 8; k++) x = x ^ m_q[k];
        m_q.push_back(x);
      end
      m_rx  = (rx_valid_si && !fifo_full)  ? 1 : 0;
      m_rd  = (read_sample && !fifo_empty) ? 1 : 0;
      m_ovf = (rx_valid_si && fifo_full)   ? 1 : 0;
      m_udf = (read_sample && fifo_empty)  ? 1 : 0;
      m_pending = 0;
    end else begin
      if (rx_valid_si && !fifo_full)  m_rx  = sat(m_rx + 1, 65535);
      if (read_sample && !fifo_empty) m_rd  = sat(m_rd + 1, 65535);
      if (rx_valid_si && fifo_full)   m_ovf = sat(m_ovf + 1, 255);
      if (read_sample && fifo_empty)  m_udf = sat(m_udf + 1, 255);
      if (tk) m_pending = 1;
    end
    if (acc) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_seq = (m_seq + 1) % 256;
    end
    m_timer = (enable && m_timer != P - 1) ? m_timer + 1 : 0;
  endtask

  task automatic cycle();
    if (tx_valid_si === 1'b1 && tx_ready_si) cap.push_back(tx_data_si);
    model_edge();
    @(posedge clk);
    #1;
    check("tx_valid", tx_valid_si, (m_q.size() != 0));
    if (m_q.size() != 0) check("tx_data", tx_data_si, m_q[0]);
  endtask

  task automatic collect(input int nbytes, input int budget, input bit toggle);
    int n = 0;
    while (cap.size() < nbytes && n < budget) begin
      if (toggle) tx_ready_si = ~tx_ready_si;
      cycle();
      n++;
    end
    check("collect_bytes", cap.size(), nbytes);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic first_period_stim();
    for (int i = 0; i < 20; i++) begin
      rx_valid_si = (i < 5);
      read_sample = (i >= 10 && i < 13);
      cycle();
    end
    rx_valid_si = 1'b0;
    read_sample = 1'b0;
  endtask

  byte unsigned exp1[9] = '{8'hA5, 8'h00, 8'h00, 8'h05, 8'h00, 8'h03, 8'h00, 8'h00, 8'h06};
  byte unsigned exp3[8] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'hFF};

  initial begin
    rst = 1'b1; enable = 1'b0; rx_valid_si = 1'b0; fifo_full = 1'b0;
    fifo_empty = 1'b0; read_sample = 1'b0; tx_ready_si = 1'b1;
    repeat (3) cycle();
    check("rst_valid", tx_valid_si, 1'b0);
    check("rst_data", tx_data_si, 8'h00);

    // Basic frame, ready always high.
    rst = 1'b0; enable = 1'b1;
    cap.delete();
    first_period_stim();
    collect(FL, 3 * P, 1'b0);
    for (int i = 0; i < FL; i++) check($sformatf("frame1_b%0d", i), cap[i], exp1[i]);

    // Same stimulus with ready toggling every cycle.
    do_reset();
    cap.delete();
    first_period_stim();
    collect(FL, 3 * P, 1'b1);
    tx_ready_si = 1'b1;
    repeat (4) cycle();
    check("toggle_count", cap.size(), FL);
    for (int i = 0; i < FL; i++) check($sformatf("frame2_b%0d", i), cap[i], exp1[i]);

    // Saturation while disabled, then report after re-enable.
    enable = 1'b0;
    do_reset();
    fifo_full = 1'b1;
    rx_valid_si = 1'b1;
    repeat (3) cycle();
    rx_valid_si = 1'b0; fifo_full = 1'b0;
    fifo_empty = 1'b1; read_sample = 1'b1;
    repeat (300) cycle();
    read_sample = 1'b0; fifo_empty = 1'b0;
    check("disabled_idle", tx_valid_si, 1'b0);
    enable = 1'b1;
    cap.delete();
    collect(FL, 3 * P, 1'b0);
    for (int i = 0; i < 8; i++) check($sformatf("sat_b%0d", i), cap[i], exp3[i]);

    // Reset while byte 4 is on the bus.
    rx_valid_si = 1'b1;
    repeat (7) cycle();
    rx_valid_si = 1'b0;
    cap.delete();
    collect(4, 3 * P, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort_valid", tx_valid_si, 1'b0);
    rx_valid_si = 1'b1;
    repeat (2) cycle();
    rx_valid_si = 1'b0;
    cap.delete();
    collect(FL, 3 * P, 1'b0);
    check("post_rst_sync", cap[0], 8'hA5);
    check("post_rst_seq", cap[1], 8'h00);
    check("post_rst_rx", cap[3], 8'h02);

    // Event on the snapshot-load edge with the host stalled past several ticks.
    tx_ready_si = 1'b0;
    begin
      int n = 0;
      while (!(m_pending && m_q.size() == 0) && n < 3 * P) begin
        cycle();
        n++;
      end
      check("wait_pending", m_pending, 1'b1);
    end
    rx_valid_si = 1'b1;
    cycle();
    rx_valid_si = 1'b0;
    repeat (2 * P + 10) cycle();
    enable = 1'b0;
    cap.delete();
    tx_ready_si = 1'b1;
    collect(2 * FL, 3 * P, 1'b0);
    repeat (P) cycle();
    check("extra_frames", cap.size(), 2 * FL);
    check("f0_rx_lo", cap[3], 8'h00);
    check("f1_rx_lo", cap[FL + 3], 8'h01);
    check("f1_seq", cap[FL + 1], 8'(cap[1] + 8'd1));

    // Random traffic against the model.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      rx_valid_si = ($urandom_range(0, 2) == 0);
      fifo_full   = ($urandom_range(0, 5) == 0);
      read_sample = ($urandom_range(0, 2) == 0);
      fifo_empty  = ($urandom_range(0, 5) == 0);
      tx_ready_si = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
